// File: rtl/approx_alu_seq.sv
// rtl/approx_alu_seq.sv - valid/ready execute-stage ALU with an iterative shift-add multiplier
// APPROX_MUL_EN selects the segmented approximate multiply; otherwise opcode 0x16 is an exact HALFxHALF product.
module approx_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             err
);
  localparam int HALF = WIDTH / 2;
`ifdef APPROX_MUL_EN
  localparam int OPW = SEG;
`else
  localparam int OPW = HALF;
`endif
  localparam int CNT_W = $clog2(OPW + 1);
  localparam int SH_W  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [OPW-1:0]    mplier_q, mplier_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  alu_res;
  logic              alu_err;
  logic              is_mul;
  logic              accept;
  logic              last_iter;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  mul_res;
  logic [SH_W-1:0]   sh_a, sh_b;
  logic [OPW-1:0]    seg_a, seg_b;

  // Returns {shift, segment}; the segment keeps the OPW bits just below and including the leading one.
  function automatic logic [SH_W+OPW-1:0] segment(input logic [HALF-1:0] x);
    logic [SH_W-1:0] s;
    s = '0;
`ifdef APPROX_MUL_EN
    for (int i = SEG; i < HALF; i++) begin
      if (x[i]) s = SH_W'(i - SEG + 1);
    end
`endif
    return {s, OPW'(x >> s)};
  endfunction

  assign {sh_a, seg_a} = segment(A[HALF-1:0]);
  assign {sh_b, seg_b} = segment(B[HALF-1:0]);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (Control)
      6'h00:               alu_res = '0;
      6'h10:               alu_res = A;
      6'h39, 6'h3B, 6'h3C: alu_res = B;
      6'h12, 6'h32:        alu_res = A + B;
      6'h13, 6'h20, 6'h33: alu_res = A - B;
      6'h14, 6'h34:        alu_res = A | B;
      6'h15, 6'h35:        alu_res = A & B;
      6'h16:               is_mul  = 1'b1;
      default:             alu_err = 1'b1;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == CNT_W'(OPW - 1));
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_res   = acc_next << sh_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_mul ? MULT : DONE;
      MULT: if (last_iter) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? MULT : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is gated by reset so the front end sees a stall while reset is held.
  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = reset & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    out_d    = out_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (accept) begin
      if (is_mul) begin
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = WIDTH'(seg_a);
        mplier_d = seg_b;
        sh_d     = sh_a + sh_b;
      end else begin
        out_d  = alu_res;
        zero_d = (alu_res == '0);
        err_d  = alu_err;
      end
    end else if (state_q == MULT) begin
      cnt_d    = cnt_q + CNT_W'(1);
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last_iter) begin
        out_d  = mul_res;
        zero_d = (mul_res == '0);
        err_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign Out  = out_q;
  assign Zero = zero_q;
  assign err  = err_q;

endmodule

// File: doc/approx_alu_seq.md
# approx_alu_seq

Sequential, parameterised successor of the CPU execute-stage ALU. It carries the same opcode map and adds a valid/ready handshake on both sides, a registered result with a registered Zero flag, and an illegal-opcode flag. The multiply opcode runs on an iterative segmented approximate multiplier that takes several cycles. The block sits between the register-read and writeback stages and stalls the front end through `in_ready` while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand and result width; must be even and at least 8.
- `SEG`, 8: approximate-multiplier segment width in bits; requires `SEG` ≤ `WIDTH/2`.
- `clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the request on `A`, `B` and `Control` is valid.
- `in_ready` out 1: the block can accept a request this cycle.
- `A` in `WIDTH`: operand A.
- `B` in `WIDTH`: operand B or immediate.
- `Control` in 6: opcode.
- `out_valid` out 1: `Out`, `Zero` and `err` hold a valid result.
- `out_ready` in 1: the consumer takes the result.
- `Out` out `WIDTH`: registered result.
- `Zero` out 1: registered flag, equal to (`Out == 0`).
- `err` out 1: the opcode was illegal.

## Operation
- A request is accepted on a rising edge where `in_valid` and `in_ready` are both high. `A`, `B` and `Control` are sampled at that edge.
- Opcode map:
  - 0x00: `Out` = 0.
  - 0x10: `Out` = A.
  - 0x39, 0x3B, 0x3C: `Out` = B.
  - 0x12, 0x32: `Out` = A+B, modulo 2^WIDTH.
  - 0x13, 0x20, 0x33: `Out` = A−B, modulo 2^WIDTH.
  - 0x14, 0x34: `Out` = A|B.
  - 0x15, 0x35: `Out` = A&B.
  - 0x16: `Out` = MUL(A[WIDTH/2−1:0], B[WIDTH/2−1:0]), an unsigned `WIDTH`-bit product.
- Any other opcode gives `Out` = 0 with `err` = 1. For every legal opcode `err` = 0.
- Approximate MUL, applied to each HALF-bit operand x, where HALF = `WIDTH/2`:
  - If x < 2^SEG, the segment is seg = x and the shift is s = 0.
  - Otherwise let p be the index of the leading one. Then s = p−SEG+1 and seg = x>>s, truncated.
  - Segments and shifts are computed combinationally at the accept edge and registered.
- Result = (segA·segB) << (sA+sB). The product is formed by shift-add, one bit of segB per cycle over `SEG` cycles. The final shift is applied on the last iteration edge.
- FSM states:
  - IDLE (`in_ready` = 1). An accepted non-MUL request goes to DONE with the result registered. An accepted MUL goes to MULT with the counter at 0.
  - MULT. The counter increments each cycle. On the final iteration the state goes to DONE with the result registered.
  - DONE (`out_valid` = 1). `Out`, `Zero` and `err` stay stable until `out_ready` is sampled high.
- DONE with `out_ready` high: if `in_valid` is also high, the new request is accepted in the same cycle (`in_ready` = `out_ready` in DONE). That gives back-to-back single-cycle ops. Otherwise the state returns to IDLE.
- `in_ready` is 0 in MULT, and in DONE when `out_ready` is low.

## Timing
- All outputs are 0 in reset: `in_ready` = 0 while `reset` is low and 1 in the first cycle after release. `Zero` resets to 0, a deliberate exception to the `Out == 0` relation.
- Non-MUL latency: accepted at edge t, `out_valid` is high from cycle t+1.
- MUL latency with the macro defined: `out_valid` from t+SEG+1.
- MUL latency without the macro: `out_valid` from t+WIDTH/2+1.
- Sustained throughput for non-MUL ops with `out_ready` tied high: one result per cycle.
- `reset` asserted mid-MULT or in DONE: state is IDLE immediately. The result is discarded and all registers clear asynchronously.
- Inputs are ignored when `in_ready` = 0.

## Configuration
- `APPROX_MUL_EN` defined: opcode 0x16 uses the segmented approximate algorithm above and takes `SEG` iterations.
- `APPROX_MUL_EN` undefined: opcode 0x16 computes the exact HALF×HALF product by shift-add over `WIDTH/2` iterations. No segmentation logic is built.
- The handshake and FSM are identical in both builds; only the iteration count and the result differ.

## Test plan
- Reset: hold `reset` low with random inputs → `out_valid` = 0, `Out` = 0, `Zero` = 0, `err` = 0, `in_ready` = 0. After release, `in_ready` = 1.
- ALU ops, `out_ready` = 1, back-to-back: ADD 0xFFFFFFFF+1, then SUB 5−5, then OR 0xF0|0x0F, then opcode 0x3F.
  - ADD → `Out` = 0, `Zero` = 1, one cycle after accept.
  - SUB → `Out` = 0, `Zero` = 1.
  - OR → `Out` = 0xFF, `Zero` = 0.
  - 0x3F → `Out` = 0, `err` = 1.
- Approximate MUL, macro defined with `SEG` = 8: A = B = 0x0000FFFF → `Out` = 0xFE010000, `out_valid` at accept+9. A=12, B=10 → `Out` = 120.
- Exact MUL, macro undefined: A = B = 0x0000FFFF → `Out` = 0xFFFE0001, `out_valid` at accept+17.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a MOV of 0x1234 → `Out` stays 0x1234 and `in_ready` = 0 throughout. Then raise `out_ready` with a new request pending → that request is accepted in the same cycle.
- Reset mid-MULT at accept+4 → `out_valid` never asserts for that request, state is IDLE, and a following ADD 2+3 returns 5.
